// File: rtl/shift_register4.sv
// Universal register: clear, parallel load, increment, decrement and serial shifts.
// One operation per cycle, picked by fixed priority; each bit is a registered mux cell.
package shift_register4_pkg;
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_DEC,
        OP_SR,
        OP_SL
    } op_e;

    // Candidate next values for a single bit, one per data-moving operation.
    typedef struct packed {
        logic ld;
        logic inc;
        logic dec;
        logic sr;
        logic sl;
    } cand_t;
endpackage

module shift_register4_cell
    import shift_register4_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  op_e   op,
    input  cand_t cand,
    output logic  q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            unique case (op)
                OP_CLR:  q <= 1'b0;
                OP_LD:   q <= cand.ld;
                OP_INC:  q <= cand.inc;
                OP_DEC:  q <= cand.dec;
                OP_SR:   q <= cand.sr;
                OP_SL:   q <= cand.sl;
                default: q <= q;
            endcase
        end
    end
endmodule

module shift_register4
    import shift_register4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;
    op_e              op;

    always_comb begin
        op = OP_HOLD;
        if (cl)       op = OP_CLR;
        else if (ld)  op = OP_LD;
        else if (inc) op = OP_INC;
        else if (dec) op = OP_DEC;
        else if (sr)  op = OP_SR;
        else if (sl)  op = OP_SL;
    end

    // Carry/borrow simply fall off the top: counting wraps modulo 2^WIDTH.
    assign sum  = q + WIDTH'(1);
    assign diff = q - WIDTH'(1);
    assign shr  = {ir, q[WIDTH-1:1]};
    assign shl  = {q[WIDTH-2:0], il};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cand_t cand;
        assign cand = '{ld: in[i], inc: sum[i], dec: diff[i], sr: shr[i], sl: shl[i]};

        shift_register4_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .op    (op),
            .cand  (cand),
            .q     (q[i])
        );
    end

    assign out = q;
endmodule

// File: tb/tb_shift_register4.sv
// Bench for shift_register4: directed vector table, reset corner cases, then
// randomized controls checked against an arithmetic reference model.
module tb_shift_register4;
    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n, cl, ld, inc, dec, sr, ir, sl, il;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n, cl, ld, inc, dec, sr, sl, ir, il;
        logic [3:0] in;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    shift_register4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (cl),
        .ld    (ld),
        .in    (in),
        .inc   (inc),
        .dec   (dec),
        .sr    (sr),
        .ir    (ir),
        .sl    (sl),
        .il    (il),
        .out   (out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic r, logic c, logic l, logic i, logic d,
                                logic s_r, logic s_l, logic i_r, logic i_l,
                                logic [3:0] din, logic [3:0] e);
        vec_t v;
        v.name = name; v.rst_n = r; v.cl = c; v.ld = l; v.inc = i; v.dec = d;
        v.sr = s_r; v.sl = s_l; v.ir = i_r; v.il = i_l; v.in = din; v.exp = e;
        return v;
    endfunction

    // Reference: the priority rules written as plain integer arithmetic.
    function automatic int model(int m, logic r, logic c, logic l, logic i, logic d,
                                 logic s_r, logic s_l, logic i_r, logic i_l, int din);
        if (!r)       return 0;
        if (c)        return 0;
        if (l)        return din;
        if (i)        return (m + 1) % MOD;
        if (d)        return (m + MOD - 1) % MOD;
        if (s_r)      return m / 2 + (i_r ? MOD / 2 : 0);
        if (s_l)      return (m * 2) % MOD + (i_l ? 1 : 0);
        return m;
    endfunction

    task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic c, logic l, logic i, logic d,
                         logic s_r, logic s_l, logic i_r, logic i_l, logic [3:0] din);
        rst_n = r; cl = c; ld = l; inc = i; dec = d;
        sr = s_r; sl = s_l; ir = i_r; il = i_l; in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;
        logic r, c, l, i, d, s_r, s_l, i_r, i_l;
        logic [3:0] din;

        //           name         rst cl ld in de sr sl ir il  in     exp
        vecs.push_back(mk("rst_ld",  0, 0, 1, 0, 0, 0, 0, 0, 0, 4'hA, 4'h0));
        vecs.push_back(mk("rel_ld",  1, 0, 1, 0, 0, 0, 0, 0, 0, 4'hA, 4'hA));
        vecs.push_back(mk("ld_e",    1, 0, 1, 0, 0, 0, 0, 0, 0, 4'hE, 4'hE));
        vecs.push_back(mk("inc_f",   1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'hF));
        vecs.push_back(mk("inc_wrap",1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk("inc_1",   1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h1));
        vecs.push_back(mk("dec_0",   1, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk("dec_wrap",1, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'hF));
        vecs.push_back(mk("ld_9a",   1, 0, 1, 0, 0, 0, 0, 0, 0, 4'h9, 4'h9));
        vecs.push_back(mk("sr_ir1",  1, 0, 0, 0, 0, 1, 0, 1, 0, 4'h0, 4'hC));
        vecs.push_back(mk("sr_ir0",  1, 0, 0, 0, 0, 1, 0, 0, 1, 4'h0, 4'h6));
        vecs.push_back(mk("ld_9b",   1, 0, 1, 0, 0, 0, 0, 0, 0, 4'h9, 4'h9));
        vecs.push_back(mk("sl_il1",  1, 0, 0, 0, 0, 0, 1, 1, 1, 4'h0, 4'h3));
        vecs.push_back(mk("sl_il0",  1, 0, 0, 0, 0, 0, 1, 1, 0, 4'h0, 4'h6));
        vecs.push_back(mk("ld_5",    1, 0, 1, 0, 0, 0, 0, 0, 0, 4'h5, 4'h5));
        vecs.push_back(mk("cl_pri",  1, 1, 1, 1, 0, 0, 0, 0, 0, 4'hA, 4'h0));
        vecs.push_back(mk("ld_pri",  1, 0, 1, 1, 0, 0, 0, 0, 0, 4'h7, 4'h7));
        vecs.push_back(mk("inc_pri", 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h8));
        vecs.push_back(mk("dec_pri", 1, 0, 0, 0, 1, 1, 0, 1, 0, 4'h0, 4'h7));
        vecs.push_back(mk("ld_6",    1, 0, 1, 0, 0, 0, 0, 0, 0, 4'h6, 4'h6));
        vecs.push_back(mk("sr_pri",  1, 0, 0, 0, 0, 1, 1, 0, 1, 4'h0, 4'h3));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk("hold",  1, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 4'h3));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].cl, vecs[k].ld, vecs[k].inc, vecs[k].dec,
                  vecs[k].sr, vecs[k].sl, vecs[k].ir, vecs[k].il, vecs[k].in);
            tick();
            chk(vecs[k].name, out, vecs[k].exp);
        end

        // Reset dropped between edges must not move out until the next edge.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'hB);
        tick();
        chk("pre_async", out, 4'hB);
        #2 rst_n = 1'b0;
        #1 chk("no_async_rst", out, 4'hB);
        inc = 1'b1; ld = 1'b0;
        tick();
        chk("sync_rst", out, 4'h0);

        // Held inc: counts every edge; mid-sequence reset discards, then resumes.
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
        tick(); chk("held_inc1", out, 4'h1);
        tick(); chk("held_inc2", out, 4'h2);
        rst_n = 1'b0;
        tick(); chk("mid_rst", out, 4'h0);
        rst_n = 1'b1;
        tick(); chk("resume", out, 4'h1);

        // Randomized controls against the reference model.
        m = int'(out);
        for (int k = 0; k < 1000; k++) begin
            r   = ($urandom_range(0, 31) != 0);
            c   = ($urandom_range(0, 15) == 0);
            l   = ($urandom_range(0, 5) == 0);
            i   = $urandom_range(0, 1);
            d   = $urandom_range(0, 1);
            s_r = $urandom_range(0, 1);
            s_l = $urandom_range(0, 1);
            i_r = $urandom_range(0, 1);
            i_l = $urandom_range(0, 1);
            din = 4'($urandom);
            drive(r, c, l, i, d, s_r, s_l, i_r, i_l, din);
            m = model(m, r, c, l, i, d, s_r, s_l, i_r, i_l, int'(din));
            tick();
            chk("random", out, WIDTH'(m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
